// File: rtl/bitslice_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bitslice_pkg
// Description : Shared sizing and word-line type for the bit-slice storage array.
// Revision    : 1.0 - initial release
// ============================================================================
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 3
`endif

package bitslice_pkg;

    localparam int ADDR_WIDTH = `ADDR_WIDTH;

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // One bit per cell; the same vector type carries DGWCLK and RWL.
    typedef logic [DEPTH-1:0] wl_t;

endpackage : bitslice_pkg
`default_nettype wire

// File: rtl/bit_cell.sv
`default_nettype none
// ============================================================================
// Module      : bit_cell
// Description : Single storage cell with a gated write and an AND-gated read port.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_cell (
    input  logic clk,
    input  logic rst,
    input  logic we,
    input  logic d,
    input  logic rwl,
    output logic rd
);

    logic r_q;

    // Reset wins over a write landing on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= 1'b0;
        end else if (we) begin
            r_q <= d;
        end
    end

    assign rd = r_q & rwl;

endmodule : bit_cell
`default_nettype wire

// File: rtl/bit_slice.sv
`default_nettype none
// ============================================================================
// Module      : bit_slice
// Description : One-bit column of DEPTH cells with one-hot writes and a wired-OR read bitline.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_slice #(
    parameter  int ADDR_WIDTH = bitslice_pkg::ADDR_WIDTH,
    localparam int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DEPTH-1:0] DGWCLK,
    input  logic             DIN,
    input  logic [DEPTH-1:0] RWL,
    output logic             DOUT
);

    import bitslice_pkg::*;

    logic [DEPTH-1:0] w_rd;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cells
            bit_cell u_cell (
                .clk (clk),
                .rst (rst),
                .we  (DGWCLK[gi]),
                .d   (DIN),
                .rwl (RWL[gi]),
                .rd  (w_rd[gi])
            );
        end
    endgenerate

    // Precharged-low bitline: no word line selected reads as 0.
    assign DOUT = |w_rd;

endmodule : bit_slice
`default_nettype wire

// File: tb/tb_bit_slice.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
// Module      : tb_bit_slice
// Description : Self-checking bench for bit_slice with directed and random stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_slice;

    localparam int C_DEPTH = 8;

    logic               clk;
    logic               rst;
    logic [C_DEPTH-1:0] dgwclk;
    logic               din;
    logic [C_DEPTH-1:0] rwl;
    logic               dout;

    // Reference contents of the column, one bit per cell.
    logic [C_DEPTH-1:0] model_mem;

    int n_total;
    int n_bad;

    bit_slice #(.ADDR_WIDTH(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .DGWCLK (dgwclk),
        .DIN    (din),
        .RWL    (rwl),
        .DOUT   (dout)
    );

    initial clk = 1'b0;
    always #1 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (rwl=%h mem=%h) at %0t",
                     tag, obs, exp, rwl, model_mem, $time);
        end
    endtask

    function automatic logic model_read(input logic [C_DEPTH-1:0] sel);
        logic any;
        any = 1'b0;
        for (int i = 0; i < C_DEPTH; i++) begin
            if (sel[i] && model_mem[i]) any = 1'b1;
        end
        return any;
    endfunction

    // One rising edge; the model applies the same cycle's controls, then we
    // sit half a nanosecond past the edge before anything is sampled.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            model_mem = '0;
        end else begin
            model_mem = (model_mem & ~dgwclk) | (din ? dgwclk : '0);
        end
        #0.5;
    endtask

    task automatic settle();
        #0.1;
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        model_mem = '0;
        rst       = 1'b0;
        dgwclk    = '0;
        din       = 1'b0;
        rwl       = '0;
        @(posedge clk);
        #0.5;

        // Reset with every write enable raised.
        rst = 1'b1; dgwclk = 8'hFF; din = 1'b1;
        step();
        rst = 1'b0; dgwclk = '0; din = 1'b0;
        for (int i = 0; i < C_DEPTH; i++) begin
            rwl = 8'(1) << i;
            settle();
            check($sformatf("reset_rwl%0d", i), dout, 1'b0);
        end
        rwl = 8'hFF;
        settle();
        check("reset_all", dout, 1'b0);

        // Basic write/read.
        din = 1'b0; dgwclk = 8'h01; rwl = 8'h00;
        step();
        din = 1'b1; dgwclk = 8'h02; rwl = 8'h01;
        step();
        dgwclk = '0;
        settle();
        check("basic_cell0", dout, 1'b0);
        rwl = 8'h02;
        settle();
        check("basic_cell1", dout, 1'b1);

        // Read during write of the same cell.
        rwl = 8'h08; dgwclk = 8'h08; din = 1'b1;
        settle();
        check("rdw_before", dout, 1'b0);
        step();
        check("rdw_after", dout, 1'b1);
        dgwclk = '0; din = 1'b0;
        step();
        step();
        check("rdw_hold", dout, 1'b1);

        // Multi-select from a clean column.
        rst = 1'b1;
        step();
        rst = 1'b0;
        dgwclk = 8'hA5; din = 1'b1;
        step();
        dgwclk = '0; din = 1'b0;
        rwl = 8'h5A; settle(); check("multi_5a", dout, 1'b0);
        rwl = 8'h80; settle(); check("multi_80", dout, 1'b1);
        rwl = 8'hFF; settle(); check("multi_ff", dout, 1'b1);
        rwl = 8'h00; settle(); check("multi_00", dout, 1'b0);

        // Reset beats a simultaneous write.
        dgwclk = 8'hFF; din = 1'b1;
        step();
        rwl = 8'hFF; settle(); check("rvw_pre", dout, 1'b1);
        rwl = 8'hFE; settle(); check("rvw_pre_nocell0", dout, 1'b1);
        rst = 1'b1; dgwclk = 8'hFF; din = 1'b1;
        step();
        rst = 1'b0; dgwclk = '0; din = 1'b0;
        rwl = 8'hFF; settle(); check("rvw_post", dout, 1'b0);

        // Random traffic against the model, checked on both sides of each edge.
        for (int n = 0; n < 1000; n++) begin
            rst    = ($urandom_range(0, 49) == 0);
            dgwclk = 8'($urandom);
            if ($urandom_range(0, 3) == 0) dgwclk = '0;
            din    = 1'($urandom);
            rwl    = 8'($urandom);
            if ($urandom_range(0, 3) == 0) rwl = 8'(1) << $urandom_range(0, 7);
            settle();
            check("rand_before", dout, model_read(rwl));
            step();
            check("rand_after", dout, model_read(rwl));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_bit_slice
`default_nettype wire
